// File: rtl/waveform_capture_if.sv
// ADC sample stream bundle (channel A, FIR channel B, valid) feeding waveform_capture.
interface waveform_capture_if #(
    parameter int unsigned DATA_W = 14
);
    logic [DATA_W-1:0] adc_a;
    logic [DATA_W-1:0] adc_b;
    logic              adc_valid;

    modport master (output adc_a, output adc_b, output adc_valid);
    modport slave  (input  adc_a, input  adc_b, input  adc_valid);
endinterface

// File: rtl/waveform_capture.sv
// Triggered two-channel waveform acquisition ahead of the UART readout.
// Optional auto-trigger on timeout is enabled by defining WFC_AUTOTRIG_EN.
module waveform_capture #(
    parameter int unsigned DEPTH         = 1000,
    parameter int unsigned DATA_W        = 14,
    parameter int unsigned DELAY_SAMPLES = 200
`ifdef WFC_AUTOTRIG_EN
    ,
    parameter int unsigned TIMEOUT_SAMPLES = 1000000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    waveform_capture_if.slave    adc,
    input  logic                 ext_trig,
    input  logic [DATA_W-1:0]    threshold,
    input  logic                 trig_source,
    input  logic                 trig_slope,
    input  logic                 delay_en,
    input  logic                 hold,
    output logic [DATA_W-1:0]    waveform    [DEPTH],
    output logic [DATA_W-1:0]    FIRwaveform [DEPTH],
    output logic [15:0]          waveNumber,
    output logic                 busy,
    output logic                 capture_done
`ifdef WFC_AUTOTRIG_EN
    ,
    output logic                 auto_trig
`endif
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DLY_W = $clog2(DELAY_SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_TRIG, S_DELAY, S_CAPTURE, S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_wave [DEPTH];
    logic [DATA_W-1:0]   r_fir  [DEPTH];
    logic [IDX_W-1:0]    r_idx;
    logic [DLY_W-1:0]    r_dly;
    logic [15:0]         r_wave_num;
    logic                r_busy;
    logic                r_done;
    logic                r_ext_s1;
    logic                r_ext_s2;
    logic                r_ext_prev;
    logic [DATA_W-1:0]   r_prev;
    logic                r_prev_valid;
    logic                r_src;
    logic                r_slope;
    logic                r_den;
    logic [DATA_W-1:0]   r_thr;

    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_valid;
    logic                w_hit;
    logic                w_force;
    logic                w_trig;

    assign w_a     = adc.adc_a;
    assign w_b     = adc.adc_b;
    assign w_valid = adc.adc_valid;

    always_comb begin
        w_hit = 1'b0;
        if (r_src)
            w_hit = r_slope ? (r_ext_prev && !r_ext_s2) : (!r_ext_prev && r_ext_s2);
        else
            w_hit = r_slope ? ((r_prev >= r_thr) && (w_a < r_thr))
                            : ((r_prev <  r_thr) && (w_a >= r_thr));
    end

`ifdef WFC_AUTOTRIG_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_forced;
    logic             r_auto;
    assign w_force   = w_valid && (r_tmo == TMO_W'(TIMEOUT_SAMPLES - 1));
    assign auto_trig = r_auto;
`else
    assign w_force = 1'b0;
`endif

    // The first valid sample after arming only primes r_prev; a forced trigger needs no history.
    assign w_trig = w_valid && ((r_prev_valid && w_hit) || w_force);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dly        <= '0;
            r_wave_num   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ext_s1     <= 1'b0;
            r_ext_s2     <= 1'b0;
            r_ext_prev   <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_src        <= 1'b0;
            r_slope      <= 1'b0;
            r_den        <= 1'b0;
            r_thr        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_wave[i] <= '0;
                r_fir[i]  <= '0;
            end
`ifdef WFC_AUTOTRIG_EN
            r_tmo    <= '0;
            r_forced <= 1'b0;
            r_auto   <= 1'b0;
`endif
        end else begin
            r_ext_s1 <= ext_trig;
            r_ext_s2 <= r_ext_s1;
            r_done   <= 1'b0;
            if (w_valid) begin
                r_prev     <= w_a;
                r_ext_prev <= r_ext_s2;
            end

            case (r_state)
                S_IDLE: begin
                    if (!hold)
                        r_state <= S_ARM;
                end
                S_ARM: begin
                    r_src        <= trig_source;
                    r_slope      <= trig_slope;
                    r_den        <= delay_en;
                    r_thr        <= threshold;
                    r_prev_valid <= 1'b0;
`ifdef WFC_AUTOTRIG_EN
                    r_tmo        <= '0;
`endif
                    r_state      <= S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    // hold wins over a coincident trigger
                    if (hold) begin
                        r_state <= S_IDLE;
                    end else if (w_valid) begin
                        r_prev_valid <= 1'b1;
`ifdef WFC_AUTOTRIG_EN
                        r_tmo <= r_tmo + TMO_W'(1);
                        if (w_trig)
                            r_forced <= !(r_prev_valid && w_hit);
`endif
                        if (w_trig) begin
                            r_busy <= 1'b1;
                            if (r_den) begin
                                r_dly   <= DLY_W'(DELAY_SAMPLES);
                                r_state <= S_DELAY;
                            end else begin
                                r_wave[0] <= w_a;
                                r_fir[0]  <= w_b;
                                r_idx     <= IDX_W'(1);
                                r_state   <= S_CAPTURE;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    if (w_valid) begin
                        r_dly <= r_dly - DLY_W'(1);
                        if (r_dly == DLY_W'(1)) begin
                            r_wave[0] <= w_a;
                            r_fir[0]  <= w_b;
                            r_idx     <= IDX_W'(1);
                            r_state   <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (w_valid) begin
                        r_wave[r_idx] <= w_a;
                        r_fir[r_idx]  <= w_b;
                        if (r_idx == IDX_W'(DEPTH - 1)) begin
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_wave_num <= r_wave_num + 16'd1;
`ifdef WFC_AUTOTRIG_EN
                            r_auto     <= r_forced;
`endif
                            r_state    <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign waveform     = r_wave;
    assign FIRwaveform  = r_fir;
    assign waveNumber   = r_wave_num;
    assign busy         = r_busy;
    assign capture_done = r_done;

endmodule

// File: tb/tb_waveform_capture.sv
// Self-checking bench for waveform_capture using a stream-level trigger/capture model.
module tb_waveform_capture;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 14;
    localparam int unsigned DLY    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ext_trig;
    logic [DATA_W-1:0] threshold;
    logic              trig_source;
    logic              trig_slope;
    logic              delay_en;
    logic              hold;
    logic [DATA_W-1:0] waveform    [DEPTH];
    logic [DATA_W-1:0] FIRwaveform [DEPTH];
    logic [15:0]       waveNumber;
    logic              busy;
    logic              capture_done;

    waveform_capture_if #(.DATA_W(DATA_W)) adc_if ();

    waveform_capture #(
        .DEPTH         (DEPTH),
        .DATA_W        (DATA_W),
        .DELAY_SAMPLES (DLY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc          (adc_if.slave),
        .ext_trig     (ext_trig),
        .threshold    (threshold),
        .trig_source  (trig_source),
        .trig_slope   (trig_slope),
        .delay_en     (delay_en),
        .hold         (hold),
        .waveform     (waveform),
        .FIRwaveform  (FIRwaveform),
        .waveNumber   (waveNumber),
        .busy         (busy),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              e;
    } samp_t;

    samp_t             q[$];
    logic [DATA_W-1:0] exp_a [DEPTH];
    logic [DATA_W-1:0] exp_b [DEPTH];
    logic [15:0]       exp_wn = '0;
    logic              h1 = 1'b0;
    logic              h2 = 1'b0;
    int                n_cmp = 0;
    int                n_bad = 0;

    // One clock: drive on the falling edge, sample outputs 1ns after the rising edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input bit e, input bit hv, input bit rv);
        @(negedge clk);
        adc_if.adc_valid = v;
        adc_if.adc_a     = a;
        adc_if.adc_b     = b;
        ext_trig         = e;
        hold             = hv;
        rst              = rv;
        @(posedge clk);
        if (rv) begin
            h2 = 1'b0;
            h1 = 1'b0;
        end else begin
            h2 = h1;
            h1 = e;
        end
        #1;
    endtask

    function automatic bit crosses(samp_t p, samp_t c, bit src, bit slope, logic [DATA_W-1:0] thr);
        if (src)
            return slope ? (p.e && !c.e) : (!p.e && c.e);
        return slope ? ((p.a >= thr) && (c.a < thr)) : ((p.a < thr) && (c.a >= thr));
    endfunction

    // Streams samples to the DUT and predicts trigger point, busy window and done pulse.
    task automatic run_session(input bit src, input bit slope, input bit den,
                               input logic [DATA_W-1:0] thr, input int mode,
                               input bit ext_init, input int ext_flip,
                               input bit hold_on_trig, input int rst_after,
                               output int done_cycles, output int seq_errs,
                               output bit completed, output bit aborted);
        logic [DATA_W-1:0] a, b;
        bit    v, e, h, would, done_now;
        int    trig_n, start_n, nv;
        samp_t c;
        trig_source = src;
        trig_slope  = slope;
        delay_en    = den;
        threshold   = thr;
        q.delete();
        done_cycles = 0;
        seq_errs    = 0;
        completed   = 1'b0;
        aborted     = 1'b0;
        trig_n      = -1;
        start_n     = 0;
        e           = ext_init;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, ext_init, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 4000 && !completed && !aborted; cyc++) begin
            nv = q.size();
            case (mode)
                0:       begin v = 1'b1;                 a = DATA_W'(7990 + nv);     end
                1:       begin v = ($urandom % 4) != 0;  a = DATA_W'(9000 - 3 * nv); end
                2:       begin v = (cyc % 2) == 0;       a = DATA_W'($urandom);      end
                default: begin v = ($urandom % 5) != 0;  a = DATA_W'($urandom);      end
            endcase
            b = DATA_W'($urandom);
            e = (cyc >= ext_flip) ? !ext_init : ext_init;
            c.a = a;
            c.b = b;
            c.e = h2;
            would = v && (trig_n < 0) && (nv >= 1) && crosses(q[nv-1], c, src, slope, thr);
            h = hold_on_trig && would;
            step(v, a, b, e, h, 1'b0);
            if (h) begin
                aborted = 1'b1;
            end else begin
                if (v) q.push_back(c);
                if (would) begin
                    trig_n  = nv;
                    start_n = nv + (den ? DLY : 0);
                end
                done_now = (trig_n >= 0) && v && (q.size() == start_n + DEPTH);
                if (busy !== ((trig_n >= 0) && !done_now)) seq_errs++;
                if (capture_done !== done_now) seq_errs++;
                done_cycles += int'(capture_done);
                if (done_now) completed = 1'b1;
                if (rst_after >= 0 && trig_n >= 0 && q.size() == start_n + rst_after) begin
                    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                    aborted = 1'b1;
                end
            end
        end
        if (aborted && hold_on_trig) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, DATA_W'($urandom), DATA_W'($urandom), e, 1'b1, 1'b0);
                if (busy !== 1'b0) seq_errs++;
            end
        end
        if (completed) begin
            step(1'b0, '0, '0, e, 1'b0, 1'b0);
            done_cycles += int'(capture_done);
            if (busy !== 1'b0) seq_errs++;
            for (int i = 0; i < DEPTH; i++) begin
                exp_a[i] = q[start_n + i].a;
                exp_b[i] = q[start_n + i].b;
            end
            exp_wn = exp_wn + 16'd1;
        end
    endtask

    task automatic test_reset();
        int bad;
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (waveNumber !== 16'd0) begin
            n_bad++; $display("FAIL reset_waveNumber: got %0d expected 0", waveNumber);
        end
        n_cmp++;
        if (busy !== 1'b0 || capture_done !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", busy, capture_done);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (waveform[i] !== '0 || FIRwaveform[i] !== '0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL reset_arrays: got %0d nonzero entries expected 0", bad);
        end
        for (int i = 0; i < DEPTH; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
        exp_wn = '0;
    endtask

    task automatic test_level_rising();
        int dc, se; bit cp, ab;
        run_session(1'b0, 1'b0, 1'b0, DATA_W'(8000), 0, 1'b0, 1 << 30, 1'b0, -1, dc, se, cp, ab);
        n_cmp++;
        if (cp !== 1'b1 || dc != 1) begin
            n_bad++; $display("FAIL rise_done: got completed=%b pulses=%0d expected 1/1", cp, dc);
        end
        n_cmp++;
        if (se != 0) begin n_bad++; $display("FAIL rise_busy_seq: got %0d bad cycles expected 0", se); end
        n_cmp++;
        if (waveform[0] !== DATA_W'(8000)) begin
            n_bad++; $display("FAIL rise_first: got %0d expected 8000", waveform[0]);
        end
        n_cmp++;
        if (waveform[DEPTH-1] !== DATA_W'(8000 + DEPTH - 1)) begin
            n_bad++; $display("FAIL rise_last: got %0d expected %0d", waveform[DEPTH-1], 8000 + DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (waveform[i] !== exp_a[i] || FIRwaveform[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL rise_data[%0d]: got %0d/%0d expected %0d/%0d",
                                  i, waveform[i], FIRwaveform[i], exp_a[i], exp_b[i]);
            end
        end
        n_cmp++;
        if (waveNumber !== exp_wn) begin
            n_bad++; $display("FAIL rise_waveNumber: got %0d expected %0d", waveNumber, exp_wn);
        end
    endtask

    task automatic test_level_falling_delay();
        int dc, se; bit cp, ab;
        run_session(1'b0, 1'b1, 1'b1, DATA_W'(8500), 1, 1'b0, 1 << 30, 1'b0, -1, dc, se, cp, ab);
        n_cmp++;
        if (cp !== 1'b1 || dc != 1 || se != 0) begin
            n_bad++; $display("FAIL fall_seq: got completed=%b pulses=%0d bad=%0d expected 1/1/0", cp, dc, se);
        end
        // crossing at valid sample 167 (8499), stored start is 5 valid samples later
        n_cmp++;
        if (waveform[0] !== DATA_W'(9000 - 3 * (167 + DLY))) begin
            n_bad++; $display("FAIL fall_first: got %0d expected %0d", waveform[0], 9000 - 3 * (167 + DLY));
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (waveform[i] !== exp_a[i] || FIRwaveform[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL fall_data[%0d]: got %0d/%0d expected %0d/%0d",
                                  i, waveform[i], FIRwaveform[i], exp_a[i], exp_b[i]);
            end
        end
        n_cmp++;
        if (waveNumber !== exp_wn) begin
            n_bad++; $display("FAIL fall_waveNumber: got %0d expected %0d", waveNumber, exp_wn);
        end
    endtask

    task automatic test_external();
        int dc, se; bit cp, ab;
        for (int k = 0; k < 2; k++) begin
            run_session(1'b1, k[0], k[0], '0, 2, k[0], 21 + 3 * k, 1'b0, -1, dc, se, cp, ab);
            n_cmp++;
            if (cp !== 1'b1 || dc != 1 || se != 0) begin
                n_bad++; $display("FAIL ext%0d_seq: got completed=%b pulses=%0d bad=%0d expected 1/1/0",
                                  k, cp, dc, se);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_cmp++;
                if (waveform[i] !== exp_a[i] || FIRwaveform[i] !== exp_b[i]) begin
                    n_bad++; $display("FAIL ext%0d_data[%0d]: got %0d/%0d expected %0d/%0d",
                                      k, i, waveform[i], FIRwaveform[i], exp_a[i], exp_b[i]);
                end
            end
            n_cmp++;
            if (waveNumber !== exp_wn) begin
                n_bad++; $display("FAIL ext%0d_waveNumber: got %0d expected %0d", k, waveNumber, exp_wn);
            end
        end
    endtask

    task automatic test_hold_abort();
        int dc, se; bit cp, ab;
        run_session(1'b0, 1'b0, 1'b0, DATA_W'(8000), 0, 1'b0, 1 << 30, 1'b1, -1, dc, se, cp, ab);
        n_cmp++;
        if (ab !== 1'b1 || cp !== 1'b0 || dc != 0 || se != 0) begin
            n_bad++; $display("FAIL hold_abort: got aborted=%b completed=%b pulses=%0d bad=%0d expected 1/0/0/0",
                              ab, cp, dc, se);
        end
        n_cmp++;
        if (waveNumber !== exp_wn) begin
            n_bad++; $display("FAIL hold_waveNumber: got %0d expected %0d", waveNumber, exp_wn);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (waveform[i] !== exp_a[i] || FIRwaveform[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL hold_kept[%0d]: got %0d/%0d expected %0d/%0d",
                                  i, waveform[i], FIRwaveform[i], exp_a[i], exp_b[i]);
            end
        end
        run_session(1'b0, 1'b0, 1'b0, DATA_W'(8000), 0, 1'b0, 1 << 30, 1'b0, -1, dc, se, cp, ab);
        n_cmp++;
        if (cp !== 1'b1 || dc != 1 || se != 0 || waveform[0] !== DATA_W'(8000)) begin
            n_bad++; $display("FAIL hold_rearm: got completed=%b pulses=%0d bad=%0d first=%0d expected 1/1/0/8000",
                              cp, dc, se, waveform[0]);
        end
        n_cmp++;
        if (waveNumber !== exp_wn) begin
            n_bad++; $display("FAIL hold_rearm_waveNumber: got %0d expected %0d", waveNumber, exp_wn);
        end
    endtask

    task automatic test_back_to_back();
        int dc, se; bit cp, ab;
        bit slope, den;
        logic [DATA_W-1:0] thr;
        for (int k = 0; k < 4; k++) begin
            slope = 1'($urandom);
            den   = 1'($urandom);
            thr   = DATA_W'($urandom_range(12000, 4000));
            run_session(1'b0, slope, den, thr, 3, 1'b0, 1 << 30, 1'b0, -1, dc, se, cp, ab);
            n_cmp++;
            if (cp !== 1'b1 || dc != 1 || se != 0) begin
                n_bad++; $display("FAIL b2b%0d_seq: got completed=%b pulses=%0d bad=%0d expected 1/1/0",
                                  k, cp, dc, se);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_cmp++;
                if (waveform[i] !== exp_a[i] || FIRwaveform[i] !== exp_b[i]) begin
                    n_bad++; $display("FAIL b2b%0d_data[%0d]: got %0d/%0d expected %0d/%0d",
                                      k, i, waveform[i], FIRwaveform[i], exp_a[i], exp_b[i]);
                end
            end
            n_cmp++;
            if (waveNumber !== exp_wn) begin
                n_bad++; $display("FAIL b2b%0d_waveNumber: got %0d expected %0d", k, waveNumber, exp_wn);
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        int dc, se, bad; bit cp, ab;
        run_session(1'b0, 1'b0, 1'b0, DATA_W'(8000), 0, 1'b0, 1 << 30, 1'b0, 5, dc, se, cp, ab);
        n_cmp++;
        if (ab !== 1'b1 || se != 0) begin
            n_bad++; $display("FAIL midrst_seq: got aborted=%b bad=%0d expected 1/0", ab, se);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (waveform[i] !== '0 || FIRwaveform[i] !== '0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL midrst_arrays: got %0d nonzero entries expected 0", bad);
        end
        n_cmp++;
        if (waveNumber !== 16'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state: got waveNumber=%0d busy=%b expected 0/0", waveNumber, busy);
        end
        exp_wn = '0;
        run_session(1'b0, 1'b0, 1'b0, DATA_W'(8000), 0, 1'b0, 1 << 30, 1'b0, -1, dc, se, cp, ab);
        n_cmp++;
        if (cp !== 1'b1 || waveNumber !== 16'd1 || waveform[0] !== DATA_W'(8000)) begin
            n_bad++; $display("FAIL midrst_recover: got completed=%b waveNumber=%0d first=%0d expected 1/1/8000",
                              cp, waveNumber, waveform[0]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        hold             = 1'b1;
        ext_trig         = 1'b0;
        threshold        = '0;
        trig_source      = 1'b0;
        trig_slope       = 1'b0;
        delay_en         = 1'b0;
        adc_if.adc_valid = 1'b0;
        adc_if.adc_a     = '0;
        adc_if.adc_b     = '0;
        test_reset();
        test_level_rising();
        test_level_falling_delay();
        test_external();
        test_hold_abort();
        test_back_to_back();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Triggered acquisition stage directly upstream of the UART handler.
- Watches the ADC sample stream and detects a trigger on either the channel-A level crossing or the external trigger input.
- After an optional post-trigger delay, stores DEPTH consecutive samples of channels A and B into the waveform and FIR-path arrays, then bumps the wave counter.
- Arming is frozen while the UART side is transmitting (hold), so the published arrays stay stable for readout.

Parameters:
- DEPTH, 1000, samples per captured waveform (array length).
- DATA_W, 14, ADC sample width.
- DELAY_SAMPLES, 200, valid samples skipped after the trigger when delay_en=1; minimum 1.
- TIMEOUT_SAMPLES, 1000000, auto-trigger interval; used only with WFC_AUTOTRIG_EN.

Ports:
- clk  in  1  sample-domain clock; single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- adc_a  in  DATA_W  channel A sample; unsigned offset-binary.
- adc_b  in  DATA_W  channel B (FIR-filtered) sample.
- adc_valid  in  1  qualifies adc_a/adc_b for this cycle.
- ext_trig  in  1  asynchronous external trigger.
- threshold  in  DATA_W  level-trigger threshold for channel A.
- trig_source  in  1  0 = channel-A level, 1 = external.
- trig_slope  in  1  0 = rising, 1 = falling.
- delay_en  in  1  1 = apply DELAY_SAMPLES before capture.
- hold  in  1  1 = downstream reading arrays; do not arm.
- waveform  out  DATA_W x DEPTH  captured channel A, index 0 = first stored sample.
- FIRwaveform  out  DATA_W x DEPTH  captured channel B, same indexing.
- waveNumber  out  16  count of completed captures.
- busy  out  1  high in DELAY or CAPTURE.
- capture_done  out  1  one-cycle pulse when a capture completes.

Behaviour:
- Reset: state IDLE.
  - waveform and FIRwaveform: all entries cleared to 0.
  - waveNumber=0, busy=0, capture_done=0, write index=0, delay counter=0, prev-sample valid flag=0.
- All processing advances only on cycles with adc_valid=1, except FSM moves IDLE->ARM and DONE->IDLE.
- ext_trig passes through a 2-FF synchronizer. Its edge is evaluated on valid cycles against the synchronized value at the previous valid cycle.
- States:
  - IDLE: if hold=0, go to ARM next cycle; else stay.
  - ARM: latch trig_source, trig_slope, delay_en and threshold into shadow registers. Clear the prev-valid flag. Go to WAIT_TRIG. Later changes to these inputs take effect only at the next ARM.
  - WAIT_TRIG: the first valid sample only loads prev and sets prev-valid; no trigger is possible on it.
    - Level rising: prev < thr and cur >= thr.
    - Level falling: prev >= thr and cur < thr.
    - External: 0->1 (rising) or 1->0 (falling) of the synchronized signal.
    - On trigger with delay off: write the current sample to index 0, set index=1, go to CAPTURE.
    - On trigger with delay on: load counter=DELAY_SAMPLES, go to DELAY; the trigger sample is not stored.
  - DELAY: decrement on each valid cycle. On the valid cycle where the counter reaches 0, write that sample to index 0 and go to CAPTURE with index=1. This makes index 0 the DELAY_SAMPLES-th valid sample after the trigger.
  - CAPTURE: on each valid cycle write both channels at index, then increment. After writing index DEPTH-1, go to DONE.
  - DONE: for one cycle, pulse capture_done=1 and set waveNumber+=1 (wraps 0xFFFF->0x0000). Then go to IDLE.
- Hold rules:
  - hold asserted during WAIT_TRIG aborts the arm: return to IDLE with no writes.
  - hold asserted during DELAY or CAPTURE does not abort; the capture completes and the downstream block gates readout on busy=0.
- Simultaneous events: a trigger and hold rising on the same valid cycle in WAIT_TRIG resolve to hold (abort, no write).
- Non-valid cycles: never write and never count.
- Reset mid-capture: immediate return to reset values on the next clock; the partial data is discarded by the clear.

Optional Feature:
- Macro WFC_AUTOTRIG_EN.
- When defined: WAIT_TRIG counts valid cycles. If TIMEOUT_SAMPLES elapse without a trigger, a forced trigger occurs, following the same delay/capture path. An extra output auto_trig is set to 1 at DONE for a forced capture, 0 otherwise, and held until the next DONE.
- When undefined: no counter, no auto_trig port; WAIT_TRIG waits indefinitely.

Test Plan:
- Level rising, threshold=8000, delay_en=0, channel-A ramp 7990..8100 step 1 -> trigger at sample 8000; waveform[0]=8000, waveform[999]=8999 (ramp continues); waveNumber=1; capture_done high exactly 1 cycle.
- Level falling, delay_en=1, DELAY_SAMPLES=200, falling ramp crossing threshold at sample k -> waveform[0] equals sample k+200; busy high from the trigger until DONE.
- External rising edge, trig_source=1, adc_valid toggling 1/0 -> 1000 stored samples with no gaps or duplicates; samples on non-valid cycles ignored.
- hold=1 during WAIT_TRIG with a qualifying crossing on the same cycle -> no write, state IDLE, waveNumber unchanged; after hold=0 the block re-arms and captures.
- Preload waveNumber to 0xFFFF via 65535 short captures (DEPTH=4 build) -> the next capture wraps waveNumber to 0; rst asserted mid-CAPTURE -> arrays all 0, waveNumber 0.
- With WFC_AUTOTRIG_EN, TIMEOUT_SAMPLES=50, flat input -> forced capture after 50 valid samples, auto_trig=1.
